// File: rtl/slv_guard_rst_ctrl.sv
// Recovery sequencer for guarded subordinates: collects fault edges, then walks one subordinate at a
// time (round-robin) through isolate -> drain -> reset -> release and reports completion/timeouts.
module slv_guard_rst_ctrl #(
  parameter int NumSub   = 1,
  parameter int CntWidth = 8,
  parameter int RstHold  = 4,
  localparam int IdxW    = (NumSub > 1) ? $clog2(NumSub) : 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [NumSub-1:0]   fault_i,
  input  logic [CntWidth-1:0] drain_budget_i,
  input  logic [CntWidth-1:0] rst_budget_i,
  output logic [NumSub-1:0]   isolate_o,
  input  logic [NumSub-1:0]   isolated_i,
  output logic [NumSub-1:0]   rst_req_o,
  input  logic [NumSub-1:0]   rst_stat_i,
  output logic                busy_o,
  output logic [IdxW-1:0]     cur_idx_o,
  output logic                irq_o,
  output logic                err_o,
  input  logic                irq_clr_i
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISOLATE,
    ST_RESET,
    ST_WAIT,
    ST_RELEASE
  } state_t;

  localparam logic [CntWidth-1:0] HoldLast = CntWidth'(RstHold - 1);

  state_t              state;
  logic [NumSub-1:0]   fault_q;
  logic [NumSub-1:0]   pending;
  logic [IdxW-1:0]     sel;
  logic [IdxW-1:0]     rr_ptr;
  logic [CntWidth-1:0] timer;

  logic [NumSub-1:0]   sel_mask;
  logic [NumSub-1:0]   set_mask;
  logic [NumSub-1:0]   clr_mask;
  logic [CntWidth-1:0] timer_inc;
  logic [IdxW-1:0]     rr_next;
  logic                hold_met;
  logic                arb_found;
  logic [IdxW-1:0]     arb_idx;
  logic [IdxW-1:0]     cand;

  assign sel_mask  = NumSub'(1) << sel;
  assign timer_inc = (timer == '1) ? timer : timer + 1'b1;
  assign hold_met  = (timer >= HoldLast);
  assign rr_next   = (sel == IdxW'(NumSub - 1)) ? '0 : sel + 1'b1;

  // The subordinate currently being serviced cannot re-arm itself; its bit clears on release.
  assign set_mask = enable_i
                  ? (fault_i & ~fault_q & ~((state != ST_IDLE) ? sel_mask : '0))
                  : '0;
  assign clr_mask = (state == ST_RELEASE) ? sel_mask : '0;

  // Round-robin pick: first pending bit at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it holding its old value (no latch).
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NumSub; k++) begin
      cand = IdxW'((int'(rr_ptr) + k) % NumSub);
      if (!arb_found && pending[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // NOTE: all registers use non-blocking assignment, so every branch below reads pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= ST_IDLE;
      fault_q   <= '0;
      pending   <= '0;
      sel       <= '0;
      rr_ptr    <= '0;
      timer     <= '0;
      isolate_o <= '0;
      rst_req_o <= '0;
      busy_o    <= 1'b0;
      cur_idx_o <= '0;
      irq_o     <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      fault_q <= fault_i;
      pending <= (pending & ~clr_mask) | set_mask;

      // A set later in this block overrides the clear: the last non-blocking write wins.
      if (irq_clr_i) begin
        irq_o <= 1'b0;
        err_o <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (arb_found) begin
            sel       <= arb_idx;
            cur_idx_o <= arb_idx;
            isolate_o <= NumSub'(1) << arb_idx;
            busy_o    <= 1'b1;
            timer     <= '0;
            state     <= ST_ISOLATE;
          end
        end

        ST_ISOLATE: begin
          if (isolated_i[sel]) begin
            rst_req_o <= sel_mask;
            timer     <= '0;
            state     <= ST_RESET;
          end else if (timer == drain_budget_i) begin
            err_o     <= 1'b1;
            rst_req_o <= sel_mask;
            timer     <= '0;
            state     <= ST_RESET;
          end else begin
            timer <= timer_inc;
          end
        end

        ST_RESET: begin
          // Budget is only honoured once the minimum hold is met; >= keeps a budget shorter
          // than the hold from leaving the sequencer stuck.
          if (hold_met && rst_stat_i[sel]) begin
            rst_req_o <= '0;
            timer     <= '0;
            state     <= ST_WAIT;
          end else if (hold_met && (timer >= rst_budget_i)) begin
            err_o     <= 1'b1;
            rst_req_o <= '0;
            timer     <= '0;
            state     <= ST_WAIT;
          end else begin
            timer <= timer_inc;
          end
        end

        ST_WAIT: begin
          if (!rst_stat_i[sel]) begin
            isolate_o <= '0;
            timer     <= '0;
            state     <= ST_RELEASE;
          end else if (timer == rst_budget_i) begin
            err_o     <= 1'b1;
            isolate_o <= '0;
            timer     <= '0;
            state     <= ST_RELEASE;
          end else begin
            timer <= timer_inc;
          end
        end

        ST_RELEASE: begin
          irq_o     <= 1'b1;
          rr_ptr    <= rr_next;
          busy_o    <= 1'b0;
          cur_idx_o <= '0;
          timer     <= '0;
          state     <= ST_IDLE;
        end

        default: begin
          isolate_o <= '0;
          rst_req_o <= '0;
          busy_o    <= 1'b0;
          cur_idx_o <= '0;
          timer     <= '0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Bench for slv_guard_rst_ctrl (4 subordinates): a reactive subordinate model answers isolate/reset
// requests with programmable delays; expected phase lengths are queued at stimulus and popped at release.
module tb_slv_guard_rst_ctrl;

  localparam int NumSub   = 4;
  localparam int CntWidth = 8;
  localparam int RstHold  = 4;

  logic                clk_i = 1'b0;
  logic                rst_i;
  logic                enable_i;
  logic [NumSub-1:0]   fault_i;
  logic [CntWidth-1:0] drain_budget_i;
  logic [CntWidth-1:0] rst_budget_i;
  logic [NumSub-1:0]   isolate_o;
  logic [NumSub-1:0]   isolated_i;
  logic [NumSub-1:0]   rst_req_o;
  logic [NumSub-1:0]   rst_stat_i;
  logic                busy_o;
  logic [1:0]          cur_idx_o;
  logic                irq_o;
  logic                err_o;
  logic                irq_clr_i;

  slv_guard_rst_ctrl #(
    .NumSub  (NumSub),
    .CntWidth(CntWidth),
    .RstHold (RstHold)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .enable_i      (enable_i),
    .fault_i       (fault_i),
    .drain_budget_i(drain_budget_i),
    .rst_budget_i  (rst_budget_i),
    .isolate_o     (isolate_o),
    .isolated_i    (isolated_i),
    .rst_req_o     (rst_req_o),
    .rst_stat_i    (rst_stat_i),
    .busy_o        (busy_o),
    .cur_idx_o     (cur_idx_o),
    .irq_o         (irq_o),
    .err_o         (err_o),
    .irq_clr_i     (irq_clr_i)
  );

  always #5 clk_i = ~clk_i;

  // One recovery scenario: subordinate, budgets, subordinate response delays, expected phase lengths.
  // d: cycles of isolate before isolated_i rises (255 = never); r: reset cycles before rst_stat_i rises
  // (255 = never); h: wait cycles rst_stat_i stays high after rst_req_o drops (255 = stuck).
  typedef struct {
    int sub;
    int db;
    int d;
    int r;
    int h;
    int rb;
    bit clr_rel;
    bit repulse;
    int exp_iso;
    int exp_req;
    int exp_wait;
    bit exp_err;
  } vec_t;

  typedef struct {
    int idx;
    int iso;
    int req;
    int wt;
    bit err;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[6];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t_fault = 0;
  int done_cnt = 0;
  int env_d, env_r, env_h;
  int iso_cnt, req_cnt, wait_cnt;
  bit req_seen, stat_on, check_lat, clr_rel, repulse, acc_err;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic env_clear();
    iso_cnt    = 0;
    req_cnt    = 0;
    wait_cnt   = 0;
    req_seen   = 1'b0;
    stat_on    = 1'b0;
    isolated_i = '0;
    rst_stat_i = '0;
  endtask

  task automatic set_env(input int db, input int d, input int r, input int h, input int rb);
    drain_budget_i = CntWidth'(db);
    rst_budget_i   = CntWidth'(rb);
    env_d = d;
    env_r = r;
    env_h = h;
  endtask

  // Advance one cycle, sample at the falling edge, then drive the subordinate's response.
  // fault_i and irq_clr_i set before a tick are therefore one-cycle pulses.
  task automatic tick();
    exp_t e;
    @(negedge clk_i);
    cyc++;
    fault_i   = '0;
    irq_clr_i = 1'b0;
    check("onehot", int'(($countones(isolate_o) <= 1) && ($countones(rst_req_o) <= 1)
                         && ((rst_req_o & ~isolate_o) == '0)), 1);
    if (busy_o && isolate_o != '0 && rst_req_o == '0 && !req_seen) begin
      iso_cnt++;
      if (iso_cnt == 1) begin
        check("seq_expected", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          check("isolate_o", int'(isolate_o), 1 << sb_q[0].idx);
          check("cur_idx_start", int'(cur_idx_o), sb_q[0].idx);
        end
        if (check_lat) begin
          check("isolate_latency", cyc - t_fault, 2);
          check_lat = 1'b0;
        end
      end
      isolated_i = (iso_cnt > env_d) ? isolate_o : '0;
    end else if (rst_req_o != '0) begin
      req_cnt++;
      req_seen   = 1'b1;
      rst_stat_i = (req_cnt > env_r) ? rst_req_o : '0;
      stat_on    = (rst_stat_i != '0);
    end else if (busy_o && isolate_o != '0 && req_seen) begin
      wait_cnt++;
      rst_stat_i = (stat_on && wait_cnt <= env_h) ? isolate_o : '0;
    end else if (busy_o && req_seen) begin
      check("seq_expected_rel", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("cur_idx", int'(cur_idx_o), e.idx);
        check("iso_cycles", iso_cnt, e.iso);
        check("req_cycles", req_cnt, e.req);
        check("wait_cycles", wait_cnt, e.wt);
        acc_err |= e.err;
        if (repulse) fault_i = NumSub'(1 << e.idx);
      end
      if (clr_rel) irq_clr_i = 1'b1;
      done_cnt++;
      env_clear();
    end
  endtask

  task automatic run_until(input int n, input int budget);
    int k;
    k = 0;
    while (done_cnt < n && k < budget) begin
      tick();
      k++;
    end
    check("seq_done_in_time", int'(done_cnt >= n), 1);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    set_env(v.db, v.d, v.r, v.h, v.rb);
    clr_rel   = v.clr_rel;
    repulse   = v.repulse;
    irq_clr_i = 1'b1;
    tick();
    check("irq_cleared", int'(irq_o), 0);
    check("err_cleared", int'(err_o), 0);
    acc_err  = 1'b0;
    done_cnt = 0;
    e = '{v.sub, v.exp_iso, v.exp_req, v.exp_wait, v.exp_err};
    sb_q.push_back(e);
    fault_i   = NumSub'(1 << v.sub);
    t_fault   = cyc;
    check_lat = 1'b1;
    run_until(1, 200);
    tick();
    check("irq_set", int'(irq_o), 1);
    check("err_flag", int'(err_o), int'(acc_err));
    check("busy_idle", int'(busy_o), 0);
    check("cur_idx_idle", int'(cur_idx_o), 0);
    if (v.clr_rel) begin
      irq_clr_i = 1'b1;
      tick();
      check("irq_after_clr", int'(irq_o), 0);
    end
    repeat (3) tick();
    check("no_reservice", int'(busy_o), 0);
    clr_rel = 1'b0;
    repulse = 1'b0;
  endtask

  initial begin
    exp_t e;
    vec_t rv;
    int k;

    //            sub db   d    r    h   rb  clr rep  iso req wait err
    vecs[0] = '{2,  20,  3,   2,   2,  20, 0,  0,   4,  4,  3,   0};
    vecs[1] = '{0,   0,  0,   0,   0,   0, 0,  0,   1,  4,  1,   0};
    vecs[2] = '{3,   5, 255,  1,   1,  20, 0,  0,   6,  4,  2,   1};
    vecs[3] = '{0,  10,  2,   6, 255,  10, 0,  0,   3,  7, 11,   1};
    vecs[4] = '{2,   8,  1, 255,   0,   5, 0,  0,   2,  6,  1,   1};
    vecs[5] = '{1,   4,  4,   3,   4,   4, 1,  1,   5,  4,  5,   0};

    rst_i     = 1'b1;
    enable_i  = 1'b1;
    fault_i   = '0;
    irq_clr_i = 1'b0;
    clr_rel   = 1'b0;
    repulse   = 1'b0;
    check_lat = 1'b0;
    acc_err   = 1'b0;
    set_env(20, 1, 0, 0, 20);
    env_clear();
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    check("rst_isolate", int'(isolate_o), 0);
    check("rst_req", int'(rst_req_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_cur_idx", int'(cur_idx_o), 0);
    check("rst_irq", int'(irq_o), 0);
    check("rst_err", int'(err_o), 0);

    // Single-fault scenarios; the last services sub 1 so the pointer ends at 2.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Faults on 0, 1, 3 together with rr_ptr = 2: service order 3, 0, 1.
    set_env(20, 1, 0, 0, 20);
    done_cnt = 0;
    acc_err  = 1'b0;
    e = '{3, 2, 4, 1, 1'b0};
    sb_q.push_back(e);
    e = '{0, 2, 4, 1, 1'b0};
    sb_q.push_back(e);
    e = '{1, 2, 4, 1, 1'b0};
    sb_q.push_back(e);
    fault_i   = 4'b1011;
    t_fault   = cyc;
    check_lat = 1'b1;
    run_until(3, 300);
    tick();
    check("multi_irq", int'(irq_o), 1);
    check("multi_err", int'(err_o), 0);
    repeat (3) tick();
    check("multi_pending_clear", int'(busy_o), 0);

    // Fault edges while disabled are not captured.
    enable_i = 1'b0;
    fault_i  = 4'b0100;
    repeat (5) tick();
    check("disabled_no_seq", int'(busy_o), 0);
    enable_i = 1'b1;

    // Reset in the RESET phase drops everything, including a second pending fault.
    set_env(20, 1, 0, 0, 20);
    e = '{2, 2, 4, 1, 1'b0};
    sb_q.push_back(e);
    fault_i = 4'b0100;
    tick();
    fault_i = 4'b0001;
    tick();
    k = 0;
    while (rst_req_o == '0 && k < 50) begin
      tick();
      k++;
    end
    check("reached_reset_phase", int'(rst_req_o), 4);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("abort_isolate", int'(isolate_o), 0);
    check("abort_req", int'(rst_req_o), 0);
    check("abort_busy", int'(busy_o), 0);
    check("abort_cur_idx", int'(cur_idx_o), 0);
    check("abort_irq", int'(irq_o), 0);
    check("abort_err", int'(err_o), 0);
    env_clear();
    sb_q.delete();
    repeat (4) tick();
    check("abort_pending_lost", int'(busy_o), 0);
    rv = '{2, 20, 1, 0, 0, 20, 1'b0, 1'b0, 2, 4, 1, 1'b0};
    run_vec(rv);

    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
